bin_request_sequencer: RTL and testbench

//  Parses the control stream that drives the arithmetic decoder. The stream is a sequence of
//  2-byte records: pState, then {bypass, numBins[6:0]}. For each record, issues per-cycle decode

---
 rtl/arith_dec_pkg.sv | 20 ++
 rtl/bin_request_sequencer.sv | 124 ++++++++++++
 tb/tb_bin_request_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/arith_dec_pkg.sv
// Shared definitions for the arithmetic-decoder control path.
//   seq_state_t       : control-stream parser states
//   CTRL_BYPASS_BIT   : bit of the second record byte that selects bypass decoding
//   CTRL_NUMBINS_MSB  : top bit of the bin-count field in the second record byte
//   BIN_WIDTH_MAX     : widest bin group Decoder can return in one cycle
//   NBIN_W            : width of the "bins minus one" fields (n_bin, bin_cnt)
package arith_dec_pkg;

  typedef enum logic [1:0] {
    S_PSTATE = 2'd0,  // waiting for the pState byte
    S_CTRL   = 2'd1,  // waiting for the {bypass, numBins} byte
    S_RUN    = 2'd2   // issuing decode requests for the current record
  } seq_state_t;

  localparam int CTRL_BYPASS_BIT  = 7;
  localparam int CTRL_NUMBINS_MSB = 6;
  localparam int BIN_WIDTH_MAX    = 4;
  localparam int NBIN_W           = $clog2(BIN_WIDTH_MAX);

endpackage

// File: rtl/bin_request_sequencer.sv
// bin_request_sequencer
//   Parses 2-byte control records (pState, then {bypass, numBins}) and turns
//   each record into per-cycle decode requests for Decoder. Bins returned by
//   Decoder are captured into a single registered output slot that the sink
//   drains with a valid/ready handshake.
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   ctrl_byte/valid/ready : control-stream byte input with handshake
//   pState, bypass      : context state and mode presented to Decoder
//   n_bin               : bins requested this cycle minus one
//   dec_en              : Decoder advances; its dec_bin is captured this cycle
//   dec_bin             : bins from Decoder, valid while dec_en=1
//   bin_out, bin_cnt    : captured bins (bit 0 first) and their count minus one
//   bin_valid, out_ready: output slot handshake
//   record_done         : pulse on the cycle the last request of a record issues
// BIN_WIDTH must lie in 1..BIN_WIDTH_MAX.
module bin_request_sequencer
  import arith_dec_pkg::*;
#(
  parameter int BIN_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           ctrl_byte,
  input  logic                 ctrl_valid,
  output logic                 ctrl_ready,
  output logic [7:0]           pState,
  output logic                 bypass,
  output logic [NBIN_W-1:0]    n_bin,
  output logic                 dec_en,
  input  logic [BIN_WIDTH-1:0] dec_bin,
  output logic [BIN_WIDTH-1:0] bin_out,
  output logic [NBIN_W-1:0]    bin_cnt,
  output logic                 bin_valid,
  input  logic                 out_ready,
  output logic                 record_done
);

  localparam logic [6:0] BW7 = 7'(BIN_WIDTH);

  seq_state_t           state;
  logic [6:0]           remaining;
  logic [6:0]           step;
  logic                 in_run;
  logic                 ctrl_hs;
  logic [BIN_WIDTH-1:0] bin_mask;

  assign in_run  = (state == S_RUN);
  // Reset gates ready so no byte is ever taken on a reset cycle.
  assign ctrl_ready = !reset && (state == S_PSTATE || state == S_CTRL);
  assign ctrl_hs    = ctrl_valid && ctrl_ready;

  // Bins consumed per request: bypass groups up to BIN_WIDTH bins, but never
  // more than are left in the record; regular decoding is one bin at a time.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    step = 7'd1;
    if (bypass) step = (remaining < BW7) ? remaining : BW7;
  end

  // A new request may issue whenever the slot is empty or is being drained
  // this same cycle, which gives one request per cycle under no backpressure.
  assign dec_en      = in_run && (!bin_valid || out_ready);
  assign n_bin       = in_run ? NBIN_W'(step - 7'd1) : '0;
  assign record_done = dec_en && (remaining == step);

  // Bits above n_bin carry whatever Decoder drives there; clear them so the
  // sink sees a clean word.
  always_comb begin
    bin_mask = '0;
    for (int i = 0; i < BIN_WIDTH; i++) bin_mask[i] = (i <= int'(n_bin));
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; blocking assignments would create ordering
  // races between these registers and the combinational request logic.
  // NOTE: the datapath registers (bin_out, bin_cnt, pState) are reset too
  // because they are externally visible and must read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_PSTATE;
      remaining <= '0;
      pState    <= '0;
      bypass    <= 1'b0;
      bin_out   <= '0;
      bin_cnt   <= '0;
      bin_valid <= 1'b0;
    end else begin
      case (state)
        S_PSTATE: begin
          if (ctrl_hs) begin
            pState <= ctrl_byte;
            state  <= S_CTRL;
          end
        end
        S_CTRL: begin
          if (ctrl_hs) begin
            bypass    <= ctrl_byte[CTRL_BYPASS_BIT];
            remaining <= ctrl_byte[CTRL_NUMBINS_MSB:0];
            // An empty record issues nothing and goes straight back.
            state     <= (ctrl_byte[CTRL_NUMBINS_MSB:0] == '0) ? S_PSTATE : S_RUN;
          end
        end
        S_RUN: begin
          if (dec_en) begin
            remaining <= remaining - step;
            if (record_done) state <= S_PSTATE;
          end
        end
        default: state <= S_PSTATE;
      endcase

      if (dec_en) begin
        bin_out   <= dec_bin & bin_mask;
        bin_cnt   <= n_bin;
        bin_valid <= 1'b1;
      end else if (out_ready) begin
        bin_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bin_request_sequencer.sv
// Self-checking bench for bin_request_sequencer (BIN_WIDTH=4).
// A record-level reference model predicts ready/request/slot behaviour each
// cycle; directed records cover the documented cases, then random records
// with random valid/ready gaps stress the handshakes.
module tb_bin_request_sequencer;

  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    ctrl_byte;
  logic          ctrl_valid;
  logic          ctrl_ready;
  logic [7:0]    pState;
  logic          bypass;
  logic [1:0]    n_bin;
  logic          dec_en;
  logic [BW-1:0] dec_bin;
  logic [BW-1:0] bin_out;
  logic [1:0]    bin_cnt;
  logic          bin_valid;
  logic          out_ready;
  logic          record_done;

  bin_request_sequencer #(.BIN_WIDTH(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl_byte  (ctrl_byte),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .pState     (pState),
    .bypass     (bypass),
    .n_bin      (n_bin),
    .dec_en     (dec_en),
    .dec_bin    (dec_bin),
    .bin_out    (bin_out),
    .bin_cnt    (bin_cnt),
    .bin_valid  (bin_valid),
    .out_ready  (out_ready),
    .record_done(record_done)
  );

  always #5 clk = ~clk;

  // Reference model: record-level view of the sequencer.
  logic [7:0]    byte_q[$];   // control bytes still to be delivered
  int            m_left;      // bins of the current record not yet requested
  bit            m_have_ps;   // pState byte taken, control byte pending
  logic [7:0]    m_ps;
  bit            m_byp;
  logic [BW-1:0] m_out;
  int            m_cnt;
  bit            m_valid;

  int total = 0;
  int bad   = 0;
  int req_bins, got_bins, done_seen, recs_nonempty;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_left = 0; m_have_ps = 0; m_ps = '0; m_byp = 0;
    m_out = '0; m_cnt = 0; m_valid = 0;
  endtask

  task automatic push_record(input logic [7:0] ps, input logic [7:0] ctl);
    byte_q.push_back(ps);
    byte_q.push_back(ctl);
    req_bins += int'(ctl[6:0]);
    if (ctl[6:0] != 7'd0) recs_nonempty++;
  endtask

  // One clock cycle: drive at negedge, check #1 later, model update at posedge.
  task automatic step_cycle(input bit rst, input bit cv, input bit ordy);
    bit            cv_eff, exp_ready, exp_en, exp_done;
    int            step;
    logic [7:0]    cb, b;
    logic [BW-1:0] db, mk;
    cv_eff = cv && (byte_q.size() > 0);
    cb     = cv_eff ? byte_q[0] : 8'($urandom);
    db     = BW'($urandom);
    reset = rst; ctrl_valid = cv_eff; ctrl_byte = cb; out_ready = ordy; dec_bin = db;
    #1;
    exp_ready = !rst && (m_left == 0);
    step      = m_byp ? ((m_left < BW) ? m_left : BW) : 1;
    exp_en    = (m_left > 0) && (!m_valid || ordy);
    exp_done  = exp_en && (m_left == step);
    check("ctrl_ready", 32'(ctrl_ready), 32'(exp_ready));
    if (!rst) begin
      check("pState",      32'(pState),      32'(m_ps));
      check("bypass",      32'(bypass),      32'(m_byp));
      check("bin_valid",   32'(bin_valid),   32'(m_valid));
      check("bin_cnt",     32'(bin_cnt),     32'(m_cnt));
      check("bin_out",     32'(bin_out),     32'(m_out));
      check("dec_en",      32'(dec_en),      32'(exp_en));
      check("n_bin",       32'(n_bin),       (m_left > 0) ? 32'(step - 1) : 32'd0);
      check("record_done", 32'(record_done), 32'(exp_done));
      if (bin_valid === 1'b1 && ordy) got_bins += int'(bin_cnt) + 1;
      if (record_done === 1'b1) done_seen++;
    end
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (cv_eff && exp_ready) begin
        b = byte_q.pop_front();
        if (!m_have_ps) begin
          m_ps = b; m_have_ps = 1;
        end else begin
          m_byp = b[7]; m_left = int'(b[6:0]); m_have_ps = 0;
        end
      end
      if (exp_en) begin
        for (int i = 0; i < BW; i++) mk[i] = (i < step);
        m_out = db & mk; m_cnt = step - 1; m_valid = 1; m_left -= step;
      end else if (ordy) begin
        m_valid = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_n(input int n, input int vpct, input int rpct);
    for (int i = 0; i < n; i++)
      step_cycle(0, $urandom_range(99) < vpct, $urandom_range(99) < rpct);
  endtask

  task automatic run_until_idle(input int vpct, input int rpct);
    int guard = 0;
    while (byte_q.size() > 0 || m_left > 0 || m_valid || m_have_ps) begin
      if (guard >= 3000) begin
        total++; bad++;
        $display("FAIL idle_timeout observed=busy expected=idle within 3000 cycles");
        break;
      end
      step_cycle(0, $urandom_range(99) < vpct, $urandom_range(99) < rpct);
      guard++;
    end
  endtask

  initial begin
    req_bins = 0; got_bins = 0; done_seen = 0; recs_nonempty = 0;
    model_clear();
    reset = 1'b1; ctrl_valid = 1'b0; ctrl_byte = '0; out_ready = 1'b1; dec_bin = '0;
    @(negedge clk);

    // Power-on reset, then idle cycles checking reset values.
    step_cycle(1, 0, 1);
    step_cycle(1, 0, 1);
    run_n(2, 0, 100);

    // Regular record: 3 single-bin requests back to back.
    push_record(8'h2A, 8'h03);
    run_until_idle(100, 100);
    run_n(1, 0, 100);

    // Bypass record of 6 bins: groups of 4 then 2.
    push_record(8'h10, 8'h86);
    run_until_idle(100, 100);

    // Empty record: no requests at all.
    push_record(8'h05, 8'h80);
    run_until_idle(100, 100);
    run_n(1, 0, 100);

    // Backpressure after the first word, then release.
    push_record(8'h07, 8'h04);
    run_n(3, 100, 100);
    run_n(4, 100, 0);
    run_until_idle(100, 100);

    // Reset during a record with 5 bins still outstanding.
    push_record(8'h33, 8'h09);
    run_n(6, 100, 100);
    step_cycle(1, 0, 1);
    req_bins = 0; got_bins = 0; done_seen = 0; recs_nonempty = 0;
    run_n(1, 0, 100);
    push_record(8'h44, 8'h82);
    run_until_idle(100, 100);

    // ctrl_valid pattern 1-0-0-1 across two records.
    push_record(8'h11, 8'h01);
    push_record(8'h22, 8'h83);
    step_cycle(0, 1, 1); step_cycle(0, 0, 1); step_cycle(0, 0, 1); step_cycle(0, 1, 1);
    step_cycle(0, 1, 1); step_cycle(0, 0, 1); step_cycle(0, 0, 1); step_cycle(0, 1, 1);
    run_until_idle(100, 100);

    // Longest bypass record, then random records with random gaps.
    push_record(8'h5A, 8'hFF);
    run_until_idle(100, 100);
    for (int r = 0; r < 40; r++)
      push_record(8'($urandom), {1'($urandom), 7'($urandom_range(0, 12))});
    run_until_idle(70, 60);
    run_n(2, 0, 100);

    // Stream-level totals since the mid-record reset.
    check("bins_total",   32'(got_bins),  32'(req_bins));
    check("records_done", 32'(done_seen), 32'(recs_nonempty));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
